// File: rtl/alien_laser_ctrl.sv
// Alien laser slot controller: three laser slots that accept fire requests,
// fall at a fixed tick rate and retire on barrier hit, ship hit or screen bottom.
module alien_laser_ctrl #(
  parameter logic [19:0] MOVE_DIV      = 20'd400000,
  parameter logic [9:0]  STEP          = 10'd2,
  parameter logic [9:0]  LASER_HEIGHT  = 10'd10,
  parameter logic [9:0]  SCREEN_BOTTOM = 10'd480,
  parameter logic [3:0]  FIRE_GAP      = 4'd8,
  parameter logic [9:0]  PARK_X        = 10'd0,
  parameter logic [9:0]  PARK_Y        = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        fireReq,
  input  logic [9:0]  fireX,
  input  logic [9:0]  fireY,
  output logic        fireAck,
  input  logic [2:0]  alienLaserHit,
  input  logic [2:0]  shipHit,
  output logic [29:0] alienLaserXcoord,
  output logic [29:0] alienLaserYcoord,
  output logic [2:0]  laserActive,
  output logic        shipHitOut
);

  typedef enum logic {StIdle, StActive} slot_st_e;

  slot_st_e          st_q [3];
  slot_st_e          st_d [3];
  logic [2:0][9:0]   x_q, x_d;
  logic [2:0][9:0]   y_q, y_d;
  logic [19:0]       tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic [3:0]        gap_q, gap_d;
  logic              fire_ack_q, fire_ack_d;
  logic              ship_hit_out_q, ship_hit_out_d;

  logic [2:0]        idle;
  logic [2:0]        retire;
  logic [2:0]        load_sel;
  logic              fire_ok;
  logic [10:0]       bottom_sum [3];

  // Retire detection and lowest-index free slot selection from start-of-cycle state
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      idle[i]       = (st_q[i] == StIdle);
      bottom_sum[i] = {1'b0, y_q[i]} + {1'b0, LASER_HEIGHT};
      retire[i]     = (st_q[i] == StActive) &&
                      (alienLaserHit[i] || shipHit[i] ||
                       (bottom_sum[i] >= {1'b0, SCREEN_BOTTOM}));
    end
    fire_ok     = fireReq && (gap_q == 4'd0) && (|idle);
    load_sel[0] = fire_ok && idle[0];
    load_sel[1] = fire_ok && idle[1] && !idle[0];
    load_sel[2] = fire_ok && idle[2] && !idle[1] && !idle[0];
  end

  // Next state: tick divider, fire gap, per-slot retire > move > load
  always_comb begin
    tick_cnt_d     = (tick_cnt_q == MOVE_DIV - 20'd1) ? 20'd0 : tick_cnt_q + 20'd1;
    tick_d         = (tick_cnt_q == MOVE_DIV - 20'd1);
    gap_d          = gap_q;
    fire_ack_d     = fire_ok;
    ship_hit_out_d = 1'b0;
    st_d           = st_q;
    x_d            = x_q;
    y_d            = y_q;

    if (fire_ok) begin
      gap_d = FIRE_GAP;
    end else if (tick_q && (gap_q != 4'd0)) begin
      gap_d = gap_q - 4'd1;
    end

    for (int i = 0; i < 3; i++) begin
      if (retire[i]) begin
        st_d[i] = StIdle;
        x_d[i]  = PARK_X;
        y_d[i]  = PARK_Y;
        if (shipHit[i]) ship_hit_out_d = 1'b1;
      end else if ((st_q[i] == StActive) && tick_q) begin
        y_d[i] = y_q[i] + STEP;
      end else if (load_sel[i]) begin
        st_d[i] = StActive;
        x_d[i]  = fireX;
        y_d[i]  = fireY;
      end
    end
  end

  // State registers; rst and attract mode both clear everything synchronously
  always_ff @(posedge clk) begin
    if (rst || !mode) begin
      tick_cnt_q     <= 20'd0;
      tick_q         <= 1'b0;
      gap_q          <= 4'd0;
      fire_ack_q     <= 1'b0;
      ship_hit_out_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        st_q[i] <= StIdle;
        x_q[i]  <= PARK_X;
        y_q[i]  <= PARK_Y;
      end
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      tick_q         <= tick_d;
      gap_q          <= gap_d;
      fire_ack_q     <= fire_ack_d;
      ship_hit_out_q <= ship_hit_out_d;
      st_q           <= st_d;
      x_q            <= x_d;
      y_q            <= y_d;
    end
  end

  // Registered outputs
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      laserActive[i] = (st_q[i] == StActive);
    end
    alienLaserXcoord = x_q;
    alienLaserYcoord = y_q;
    fireAck          = fire_ack_q;
    shipHitOut       = ship_hit_out_q;
  end

endmodule
